// File: rtl/clk_ctrl_pkg.sv
// Shared types and default timing for the clock mode/sequencing controller.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10
    } mode_t;

    localparam int unsigned HOLD_CYCLES_DEF   = 50_000_000;
    localparam int unsigned REPEAT_CYCLES_DEF = 10_000_000;
    localparam int unsigned TIMEOUT_S_DEF     = 10;

endpackage

// File: rtl/ctrl_ajuste_relogio_if.sv
// Control/status bundle between the mode controller and the BCD counter chain.
interface ctrl_ajuste_relogio_if;

    logic sec_at_max;
    logic min_at_max;
    logic sec_enable;
    logic sec_incremento;
    logic sec_clear;
    logic min_enable;
    logic min_incremento;
    logic hr_enable;
    logic hr_incremento;

    modport master (
        input  sec_at_max, min_at_max,
        output sec_enable, sec_incremento, sec_clear,
               min_enable, min_incremento,
               hr_enable, hr_incremento
    );

    modport slave (
        output sec_at_max, min_at_max,
        input  sec_enable, sec_incremento, sec_clear,
               min_enable, min_incremento,
               hr_enable, hr_incremento
    );

endinterface

// File: rtl/btn_cond.sv
// Push-button conditioner: 2-flop sync, registered edge, registered one-cycle pulse,
// optional hold-to-autorepeat.
module btn_cond #(
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic maqh_clock,
    input  logic maqh_reset,
    input  logic btn_i,
    output logic pulse_o,
    output logic held_o
);

    localparam int unsigned MAX_C = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CW    = $clog2(MAX_C + 1);

    logic          sync1_q, sync2_q, prev_q, edge_q, pulse_q;
    logic          armed_q, armed_d;
    logic          phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] limit_c;
    logic          fire_c;

    always_ff @(posedge maqh_clock or negedge maqh_reset) begin
        if (!maqh_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
            pulse_q <= 1'b0;
            armed_q <= 1'b0;
            phase_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q & ~prev_q;
            pulse_q <= edge_q | fire_c;
            armed_q <= armed_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q is 0 in the first-pulse cycle; phase 0 waits out the hold, phase 1 the repeat period
    always_comb begin
        armed_d = armed_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        fire_c  = 1'b0;
        limit_c = phase_q ? CW'(REPEAT_CYCLES - 1) : CW'(HOLD_CYCLES - 1);
        if (!sync2_q) begin
            armed_d = 1'b0;
            phase_d = 1'b0;
            cnt_d   = '0;
        end else if (edge_q) begin
            armed_d = REPEAT_EN;
            phase_d = 1'b0;
            cnt_d   = '0;
        end else if (armed_q) begin
            if (cnt_q == limit_c) begin
                fire_c  = 1'b1;
                phase_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign pulse_o = pulse_q;
    assign held_o  = sync2_q;

endmodule

// File: rtl/ctrl_ajuste_relogio.sv
// Mode/sequencing controller for the digital clock: RUN cascade, hour/minute set
// modes with autorepeat, inactivity timeout and display blink flags.
module ctrl_ajuste_relogio
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int unsigned TIMEOUT_S     = TIMEOUT_S_DEF
) (
    input  logic                   maqh_clock,
    input  logic                   maqh_reset,
    input  logic                   tick_1hz,
    input  logic                   btn_mode,
    input  logic                   btn_inc,
    ctrl_ajuste_relogio_if.master  cnt,
    output logic [1:0]             mode,
    output logic                   blink_h,
    output logic                   blink_m
);

    localparam int unsigned TW = $clog2(TIMEOUT_S + 1);

    logic mode_pulse, mode_held, inc_pulse, inc_held;

    btn_cond #(
        .REPEAT_EN     (1'b0),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_btn_mode (
        .maqh_clock (maqh_clock),
        .maqh_reset (maqh_reset),
        .btn_i      (btn_mode),
        .pulse_o    (mode_pulse),
        .held_o     (mode_held)
    );

    btn_cond #(
        .REPEAT_EN     (1'b1),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_btn_inc (
        .maqh_clock (maqh_clock),
        .maqh_reset (maqh_reset),
        .btn_i      (btn_inc),
        .pulse_o    (inc_pulse),
        .held_o     (inc_held)
    );

    mode_t         mode_q, mode_d;
    logic [TW-1:0] to_q, to_d;
    logic          blink_q, blink_d;
    logic          alive_q;

    logic sec_en_c, sec_inc_c, sec_clr_c;
    logic min_en_c, min_inc_c, hr_en_c, hr_inc_c;
    logic inc_ok_c;

    // alive_q keeps every control low while reset is asserted
    always_ff @(posedge maqh_clock or negedge maqh_reset) begin
        if (!maqh_reset) begin
            mode_q  <= RUN;
            to_q    <= '0;
            blink_q <= 1'b0;
            alive_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            to_q    <= to_d;
            blink_q <= blink_d;
            alive_q <= 1'b1;
        end
    end

    always_comb begin
        mode_d    = mode_q;
        to_d      = to_q;
        blink_d   = blink_q;
        sec_en_c  = 1'b0;
        sec_inc_c = 1'b0;
        sec_clr_c = 1'b0;
        min_en_c  = 1'b0;
        min_inc_c = 1'b0;
        hr_en_c   = 1'b0;
        hr_inc_c  = 1'b0;
        inc_ok_c  = inc_pulse & ~mode_pulse;

        case (mode_q)
            RUN: begin
                sec_en_c  = alive_q;
                min_en_c  = alive_q;
                hr_en_c   = alive_q;
                sec_inc_c = alive_q & tick_1hz;
                min_inc_c = alive_q & tick_1hz & cnt.sec_at_max;
                hr_inc_c  = alive_q & tick_1hz & cnt.sec_at_max & cnt.min_at_max;
                if (mode_pulse) begin
                    mode_d    = SET_H;
                    sec_clr_c = 1'b1;
                end
            end
            SET_H: begin
                hr_en_c  = 1'b1;
                hr_inc_c = inc_ok_c;
                if (mode_pulse) mode_d = SET_M;
            end
            SET_M: begin
                min_en_c  = 1'b1;
                min_inc_c = inc_ok_c;
                if (mode_pulse) mode_d = RUN;
            end
            default: mode_d = RUN;
        endcase

        // inactivity timeout and blink phase only run in the set modes; a held button counts as activity
        if (mode_q != RUN) begin
            if (mode_pulse || inc_pulse) begin
                to_d = '0;
            end else if (tick_1hz && !mode_held && !inc_held && (to_q < TW'(TIMEOUT_S))) begin
                to_d = to_q + TW'(1);
            end
            if (tick_1hz) blink_d = ~blink_q;
            if (to_d == TW'(TIMEOUT_S)) mode_d = RUN;
        end

        if (mode_d == RUN) begin
            to_d    = '0;
            blink_d = 1'b0;
        end
    end

    assign cnt.sec_enable     = sec_en_c;
    assign cnt.sec_incremento = sec_inc_c;
    assign cnt.sec_clear      = sec_clr_c;
    assign cnt.min_enable     = min_en_c;
    assign cnt.min_incremento = min_inc_c;
    assign cnt.hr_enable      = hr_en_c;
    assign cnt.hr_incremento  = hr_inc_c;

    assign mode    = mode_q;
    assign blink_h = (mode_q == SET_H) & blink_q & ~inc_held;
    assign blink_m = (mode_q == SET_M) & blink_q & ~inc_held;

endmodule

// File: doc/ctrl_ajuste_relogio.md
Name: ctrl_ajuste_relogio

Overview:
- Mode/sequencing controller for the digital clock's BCD counter chain (seconds, minutes and hour machines).
- In RUN it turns the 1 Hz tick into the seconds→minutes→hours increment cascade.
- In SET_H / SET_M it freezes time and turns conditioned push-button presses into single increments, with autorepeat, on the selected field.
- Also drives blink flags for the display and returns to RUN after an inactivity timeout.

Parameters:
- HOLD_CYCLES, 50_000_000: cycles btn_inc must stay held after its first pulse before autorepeat starts.
- REPEAT_CYCLES, 10_000_000: cycles between autorepeat pulses while btn_inc stays held.
- TIMEOUT_S, 10: tick_1hz pulses without any button pulse in a set mode before forcing RUN.

Ports:
- maqh_clock  input  1  system clock
- maqh_reset  input  1  async active-low reset
- tick_1hz  input  1  one-cycle pulse, once per second
- btn_mode  input  1  raw mode button, active-high, asynchronous
- btn_inc  input  1  raw increment button, active-high, asynchronous
- sec_at_max  input  1  seconds counter currently at 59
- min_at_max  input  1  minutes counter currently at 59
- sec_enable / sec_incremento  output  1 / 1  seconds machine controls
- sec_clear  output  1  one-cycle synchronous clear of the seconds machine
- min_enable / min_incremento  output  1 / 1  minutes machine controls
- hr_enable / hr_incremento  output  1 / 1  hour machine controls; the hour counter advances only when both are high
- mode  output  2  current mode (mode_t)
- blink_h / blink_m  output  1 / 1  high = blank that display field this cycle

Behaviour:
- Reset: maqh_reset asynchronous, active-low; clock maqh_clock.
  - mode=RUN; all outputs 0; all sync, edge, repeat, timeout and blink registers 0.
  - Reset asserted mid-hold or mid-set-mode aborts the operation and returns to RUN.
- Button conditioning, per button:
  - 2-flop synchronizer, then rising-edge detect, then registered pulse.
  - First pulse is high exactly 3 clock edges after the first edge that samples the raw button high; width is 1 cycle.
  - btn_mode: no autorepeat.
  - btn_inc autorepeat: counter starts at the first pulse. If still held, an extra pulse fires at HOLD_CYCLES after the first pulse, then every REPEAT_CYCLES after that. Release (synchronized low) clears the counter immediately.
- FSM (mode_t):
  - RUN→SET_H on mode pulse; sec_clear pulses 1 cycle in the transition cycle.
  - SET_H→SET_M on mode pulse.
  - SET_M→RUN on mode pulse.
  - SET_H/SET_M→RUN when the timeout counter reaches TIMEOUT_S.
- RUN, all combinational from registered mode and inputs:
  - sec_enable=min_enable=hr_enable=1.
  - sec_incremento=tick_1hz.
  - min_incremento=tick_1hz & sec_at_max.
  - hr_incremento=tick_1hz & sec_at_max & min_at_max.
  - Inc pulses are ignored.
- SET_H:
  - hr_enable=1, hr_incremento=inc pulse.
  - min_enable=sec_enable=0.
  - tick_1hz does not advance time.
- SET_M:
  - min_enable=1, min_incremento=inc pulse.
  - hr_enable=sec_enable=0.
- Simultaneous mode and inc pulses in the same cycle: mode wins and the inc pulse is dropped.
- Timeout:
  - Counts tick_1hz only in set modes.
  - Cleared on any mode or inc pulse, and on entering RUN.
  - Saturates at TIMEOUT_S.
  - At TIMEOUT_S, mode=RUN on the next edge.
- Blink:
  - blink_phase toggles on each tick_1hz in set modes and is forced to 0 in RUN.
  - blink_h = (mode==SET_H) & blink_phase & ~btn_inc_held.
  - blink_m is the same, using SET_M.
  - Field stays visible while the button is held.
- Counter widths: $clog2(param+1); no wrap (saturate or clear only).

Decomposition:
- Package clk_ctrl_pkg:
  - typedef enum logic[1:0] mode_t {RUN=2'b00, SET_H=2'b01, SET_M=2'b10}.
  - Default timing constants.
- Sub-module btn_cond:
  - Parameters: REPEAT_EN, HOLD_CYCLES, REPEAT_CYCLES.
  - Outputs: pulse, held.
  - Instantiated twice: mode with REPEAT_EN=0, inc with REPEAT_EN=1.

Test Plan (HOLD_CYCLES=8, REPEAT_CYCLES=4, TIMEOUT_S=3):
- Reset: pull maqh_reset low at any time → mode=00, every output 0; release → still RUN, no spurious pulses.
- RUN cascade:
  - tick with sec_at_max=1, min_at_max=1 → sec/min/hr_incremento all 1 that same cycle.
  - tick with sec_at_max=0 → only sec_incremento=1.
- Mode cycling: 3 separated btn_mode presses → mode 01, 10, 00; sec_clear exactly 1 cycle, only at RUN→SET_H.
- SET_H single press: btn_inc high 5 cycles → exactly one hr_incremento pulse, 3 edges after press; hr_enable=1, min_enable=0; a tick in SET_H gives zero increments.
- Autorepeat: in SET_M, hold btn_inc for 18 cycles after the first pulse → min_incremento pulses at offsets 0, 8, 12, 16 (4 total); none after release.
- Timeout/priority:
  - SET_M with no presses for 3 ticks → mode=00 the edge after the 3rd tick.
  - btn_mode and btn_inc rising in the same cycle in SET_H → mode=10, no hr_incremento.
